// File: rtl/intsq_pkg.sv
// Shared types and helpers for the interrupt sequencer: FSM state encoding,
// the timer source index and a fixed-priority encoder.
package intsq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SAVE    = 2'd1,
      VECTOR  = 2'd2,
      SERVICE = 2'd3
   } intsqState_t;

   localparam int TIMER_IRQ = 0;

   // Lowest set index wins; returns 0 when nothing is set.
   function automatic logic [4:0] prio_enc(input logic [31:0] req);
      prio_enc = 5'd0;
      for (int i = 31; i >= 0; i--) begin
         if (req[i]) prio_enc = 5'(i);
      end
   endfunction

endpackage

// File: rtl/interrupt_sequencer_quantum_timer.sv
// Preemption quantum counter: counts retired instructions and pulses tick
// on the retire that completes a quantum.
module quantum_timer #(
   parameter int QCNT_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              quantumWe,
   input  logic [QCNT_W-1:0] quantumDin,
   input  logic              instrRetire,
   input  logic              freeze,
   output logic              tick
);

   logic [QCNT_W-1:0] quantumReg;
   logic [QCNT_W-1:0] qcntReg;
   logic              advance;
   logic              wrap;

   assign advance = instrRetire && !freeze && (quantumReg != '0);
   assign wrap    = (qcntReg == quantumReg - QCNT_W'(1));
   // A quantum write restarts the count, so no tick on that cycle.
   assign tick    = advance && wrap && !quantumWe;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         quantumReg <= '0;
         qcntReg    <= '0;
      end else if (quantumWe) begin
         quantumReg <= quantumDin;
         qcntReg    <= '0;
      end else if (advance) begin
         qcntReg <= wrap ? '0 : qcntReg + QCNT_W'(1);
      end
   end

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: edge-detects requests, picks a winner by fixed
// priority and drives the PC-source mux selects through SAVE/VECTOR/SERVICE.
module interrupt_sequencer
   import intsq_pkg::*;
#(
   parameter int N_IRQ  = 8,
   parameter int QCNT_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [N_IRQ-1:0]  irq_in,
   input  logic              irq_mask_we,
   input  logic [N_IRQ-1:0]  irq_mask_din,
   input  logic              quantum_we,
   input  logic [QCNT_W-1:0] quantum_din,
   input  logic              instr_retire,
   input  logic              reti,
   output logic              save_pc,
   output logic              save_pc_buffer,
   output logic              get_interruption,
   output logic [31:0]       irq_code,
   output logic              rf_write,
   output logic              pc_stall,
   output logic              in_service
);

   localparam int IDX_W = $clog2(N_IRQ);

   intsqState_t      stateReg;
   logic [IDX_W-1:0] winnerReg;
   logic [N_IRQ-1:0] pendingReg;
   logic [N_IRQ-1:0] maskReg;
   logic [N_IRQ-1:0] irqPrevReg;
   logic [N_IRQ-1:0] setVec;
   logic [N_IRQ-1:0] clrVec;
   logic [N_IRQ-1:0] eligible;
   logic [IDX_W-1:0] winIdx;
   logic             qTick;
   logic             unusedIrq0;

   logic             savePcReg;
   logic             savePcBufferReg;
   logic             getInterruptionReg;
   logic [31:0]      irqCodeReg;
   logic             rfWriteReg;
   logic             pcStallReg;
   logic             inServiceReg;

   // Bit 0 of irq_in is not a request line; the timer owns that source.
   assign unusedIrq0 = irq_in[0];

   quantum_timer #(.QCNT_W(QCNT_W)) u_quantum_timer (
      .clock       (clock),
      .reset       (reset),
      .quantumWe   (quantum_we),
      .quantumDin  (quantum_din),
      .instrRetire (instr_retire),
      .freeze      (inServiceReg),
      .tick        (qTick)
   );

   assign setVec[TIMER_IRQ] = qTick;
   assign clrVec[TIMER_IRQ] = (stateReg == VECTOR) && (winnerReg == IDX_W'(TIMER_IRQ));

   genvar gi;
   generate
      for (gi = 1; gi < N_IRQ; gi++) begin : gen_src
         assign setVec[gi] = irq_in[gi] & ~irqPrevReg[gi];
         assign clrVec[gi] = (stateReg == VECTOR) && (winnerReg == IDX_W'(gi));
      end
   endgenerate

   assign eligible = pendingReg & maskReg;
   assign winIdx   = IDX_W'(prio_enc(32'(eligible)));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pendingReg <= '0;
         maskReg    <= '0;
         irqPrevReg <= '0;
      end else begin
         irqPrevReg <= irq_in;
         pendingReg <= (pendingReg & ~clrVec) | setVec;
         if (irq_mask_we) maskReg <= irq_mask_din;
      end
   end

   // Outputs are loaded together with the next state so they line up with it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stateReg           <= IDLE;
         winnerReg          <= '0;
         savePcReg          <= 1'b0;
         savePcBufferReg    <= 1'b0;
         getInterruptionReg <= 1'b0;
         irqCodeReg         <= '0;
         rfWriteReg         <= 1'b0;
         pcStallReg         <= 1'b0;
         inServiceReg       <= 1'b0;
      end else begin
         case (stateReg)
            IDLE: begin
               if ((eligible != '0) && instr_retire) begin
                  winnerReg  <= winIdx;
                  stateReg   <= SAVE;
                  rfWriteReg <= 1'b1;
                  pcStallReg <= 1'b1;
                  if (winIdx == IDX_W'(TIMER_IRQ)) savePcBufferReg <= 1'b1;
                  else                             savePcReg       <= 1'b1;
               end
            end
            SAVE: begin
               savePcReg          <= 1'b0;
               savePcBufferReg    <= 1'b0;
               getInterruptionReg <= 1'b1;
               irqCodeReg         <= 32'(winnerReg);
               stateReg           <= VECTOR;
            end
            VECTOR: begin
               getInterruptionReg <= 1'b0;
               irqCodeReg         <= '0;
               rfWriteReg         <= 1'b0;
               pcStallReg         <= 1'b0;
               inServiceReg       <= 1'b1;
               stateReg           <= SERVICE;
            end
            SERVICE: begin
               if (reti) begin
                  inServiceReg <= 1'b0;
                  stateReg     <= IDLE;
               end
            end
            default: stateReg <= IDLE;
         endcase
      end
   end

   assign save_pc          = savePcReg;
   assign save_pc_buffer   = savePcBufferReg;
   assign get_interruption = getInterruptionReg;
   assign irq_code         = irqCodeReg;
   assign rf_write         = rfWriteReg;
   assign pc_stall         = pcStallReg;
   assign in_service       = inServiceReg;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer; expected output patterns are hand-derived.
module tb_interrupt_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  irq_in = '0;
   logic        irq_mask_we = 1'b0;
   logic [7:0]  irq_mask_din = '0;
   logic        quantum_we = 1'b0;
   logic [15:0] quantum_din = '0;
   logic        instr_retire = 1'b0;
   logic        reti = 1'b0;
   logic        save_pc, save_pc_buffer, get_interruption, rf_write, pc_stall, in_service;
   logic [31:0] irq_code;

   int nCompared   = 0;
   int nMismatched = 0;

   // Flag order: {save_pc, save_pc_buffer, get_interruption, rf_write, pc_stall, in_service}
   localparam logic [5:0] F_IDLE    = 6'b000000;
   localparam logic [5:0] F_SAVE    = 6'b100110;
   localparam logic [5:0] F_SAVEBUF = 6'b010110;
   localparam logic [5:0] F_VECTOR  = 6'b001110;
   localparam logic [5:0] F_SERVICE = 6'b000001;

   always #5 clock = ~clock;

   interrupt_sequencer dut (
      .clock            (clock),
      .reset            (reset),
      .irq_in           (irq_in),
      .irq_mask_we      (irq_mask_we),
      .irq_mask_din     (irq_mask_din),
      .quantum_we       (quantum_we),
      .quantum_din      (quantum_din),
      .instr_retire     (instr_retire),
      .reti             (reti),
      .save_pc          (save_pc),
      .save_pc_buffer   (save_pc_buffer),
      .get_interruption (get_interruption),
      .irq_code         (irq_code),
      .rf_write         (rf_write),
      .pc_stall         (pc_stall),
      .in_service       (in_service)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      if (obs !== exp) begin
         nMismatched++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   task automatic expectOut(input string tag, input logic [5:0] flags, input logic [31:0] code);
      chk({tag, ".flags"}, 32'({save_pc, save_pc_buffer, get_interruption,
                                rf_write, pc_stall, in_service}), 32'(flags));
      chk({tag, ".code"}, irq_code, code);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic setMask(input logic [7:0] m);
      irq_mask_we = 1'b1; irq_mask_din = m;
      step();
      irq_mask_we = 1'b0;
   endtask

   task automatic pulse(input logic [7:0] lines);
      irq_in = lines;
      step();
      irq_in = '0;
   endtask

   task automatic retire();
      instr_retire = 1'b1;
      step();
      instr_retire = 1'b0;
   endtask

   task automatic doReti();
      reti = 1'b1;
      step();
      reti = 1'b0;
   endtask

   initial begin
      step(); step();
      reset = 1'b1;
      expectOut("reset", F_IDLE, 32'd0);
      chk("reset.pending", 32'(dut.pendingReg), 32'd0);

      // Reset mid-sequence
      setMask(8'hFF);
      pulse(8'h08);
      retire();
      expectOut("rst_mid.save", F_SAVE, 32'd0);
      step();
      expectOut("rst_mid.vector", F_VECTOR, 32'd3);
      reset = 1'b0;
      #1;
      expectOut("rst_mid.async", F_IDLE, 32'd0);
      step();
      reset = 1'b1;
      step();
      chk("rst_mid.pending", 32'(dut.pendingReg), 32'd0);
      expectOut("rst_mid.idle", F_IDLE, 32'd0);

      // Single request
      setMask(8'h08);
      pulse(8'h08);
      expectOut("single.pend_idle", F_IDLE, 32'd0);
      retire();
      expectOut("single.save", F_SAVE, 32'd0);
      step();
      expectOut("single.vector", F_VECTOR, 32'd3);
      step();
      expectOut("single.service", F_SERVICE, 32'd0);
      retire();
      expectOut("single.service_hold", F_SERVICE, 32'd0);
      doReti();
      expectOut("single.reti", F_IDLE, 32'd0);

      // Priority
      setMask(8'hFF);
      pulse(8'h24);
      retire();
      expectOut("prio.save", F_SAVE, 32'd0);
      step();
      expectOut("prio.vector2", F_VECTOR, 32'd2);
      step();
      doReti();
      expectOut("prio.reti", F_IDLE, 32'd0);
      retire();
      expectOut("prio.save5", F_SAVE, 32'd0);
      step();
      expectOut("prio.vector5", F_VECTOR, 32'd5);
      step();
      doReti();

      // Quantum timer
      setMask(8'h01);
      quantum_we = 1'b1; quantum_din = 16'd4;
      step();
      quantum_we = 1'b0;
      retire(); retire(); retire();
      chk("quantum.after3", 32'(dut.pendingReg), 32'd0);
      retire();
      chk("quantum.after4", 32'(dut.pendingReg), 32'd1);
      expectOut("quantum.idle", F_IDLE, 32'd0);
      retire();
      expectOut("quantum.save", F_SAVEBUF, 32'd0);
      step();
      expectOut("quantum.vector", F_VECTOR, 32'd0);
      step();
      expectOut("quantum.service", F_SERVICE, 32'd0);
      doReti();
      quantum_we = 1'b1; quantum_din = 16'd0;
      step();
      quantum_we = 1'b0;

      // Masking
      setMask(8'h00);
      pulse(8'h10);
      retire();
      expectOut("mask.blocked", F_IDLE, 32'd0);
      chk("mask.pending", 32'(dut.pendingReg), 32'h10);
      setMask(8'h10);
      retire();
      expectOut("mask.save", F_SAVE, 32'd0);
      step();
      expectOut("mask.vector", F_VECTOR, 32'd4);
      step();
      doReti();

      // Collision: new edge on the winner during its VECTOR cycle
      setMask(8'h08);
      pulse(8'h08);
      retire();
      step();
      expectOut("coll.vector", F_VECTOR, 32'd3);
      pulse(8'h08);
      expectOut("coll.service", F_SERVICE, 32'd0);
      chk("coll.pending", 32'(dut.pendingReg), 32'h08);
      doReti();
      retire();
      expectOut("coll.save", F_SAVE, 32'd0);
      step();
      expectOut("coll.vector2", F_VECTOR, 32'd3);
      step();
      doReti();
      chk("coll.pending_clr", 32'(dut.pendingReg), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
